id_ex_hazard_reg: RTL and testbench

//  ID/EX pipeline register with built-in load-use hazard detection. It feeds the EX-stage forwarding mux and the forwarding unit with IR/operands/control.
//  On a load-use hazard it holds PC and IF/ID for LU_STALL cycles and inserts bubbles into EX.
//  A branch/jump flush kills the ID instruction. Flush has priority over stall.

---
 rtl/id_ex_hazard_reg.sv | 177 +++++++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, stall FSM and NOP insertion.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module id_ex_hazard_reg #(
    parameter int LU_STALL = 1,
    parameter int CTRL_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       IR_IF_ID_out,
    input  logic [31:0]       PC_IF_ID_out,
    input  logic [31:0]       RegA_ID,
    input  logic [31:0]       RegB_ID,
    input  logic              RegWrite_ID,
    input  logic [1:0]        RegDst_ID,
    input  logic              MemRead_ID,
    input  logic              MemWrite_ID,
    input  logic [CTRL_W-1:0] Ctrl_ID,
    input  logic              Flush_ID,
    output logic [31:0]       IR_ID_EX_out,
    output logic [31:0]       PC_ID_EX_out,
    output logic [31:0]       RegA_ID_EX_out,
    output logic [31:0]       RegB_ID_EX_out,
    output logic              RegWrite_ID_EX_out,
    output logic              MemRead_ID_EX_out,
    output logic              MemWrite_ID_EX_out,
    output logic [1:0]        RegDst_ID_EX_out,
    output logic [CTRL_W-1:0] Ctrl_ID_EX_out,
    output logic              Stall_IF_ID,
    output logic              Bubble_ID_EX,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt
);

    typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       ir_q, ir_d, pc_q, pc_d, rega_q, rega_d, regb_q, regb_d;
    logic              rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, bubble_q, bubble_d;
    logic [1:0]        rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              haz_s, stall_s, load_bubble_s;
    logic              unused_ir_bits_s;

    // Only the rs/rt fields of the ID instruction take part in hazard detection.
    assign unused_ir_bits_s = ^{IR_IF_ID_out[31:26], IR_IF_ID_out[15:0]};

    // rt of the load in EX is compared against both rs and rt of ID (conservative).
    assign haz_s = mr_q && (rd_q == 2'b00) && (ir_q[20:16] != 5'd0) &&
                   ((ir_q[20:16] == IR_IF_ID_out[25:21]) ||
                    (ir_q[20:16] == IR_IF_ID_out[20:16]));

    assign stall_s       = (((state_q == IDLE) && haz_s) || (state_q == STALL)) && !Flush_ID;
    assign load_bubble_s = Flush_ID || stall_s;

    // Stall FSM next state: IDLE starts a multi-cycle stall, STALL counts it down.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (haz_s && !Flush_ID && (LU_STALL > 1)) begin
                    state_d = STALL;
                    cnt_d   = 3'(LU_STALL - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            STALL: begin
                if (Flush_ID || (cnt_q == 3'd1)) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Pipeline register next state: bubble on flush or stall, otherwise capture ID.
    always_comb begin
        ir_d     = IR_IF_ID_out;
        pc_d     = PC_IF_ID_out;
        rega_d   = RegA_ID;
        regb_d   = RegB_ID;
        rw_d     = RegWrite_ID;
        rd_d     = RegDst_ID;
        mr_d     = MemRead_ID;
        mw_d     = MemWrite_ID;
        ctrl_d   = Ctrl_ID;
        bubble_d = 1'b0;
        if (load_bubble_s) begin
            // PC and operands keep their old values; EX ignores them for a NOP.
            ir_d     = 32'd0;
            pc_d     = pc_q;
            rega_d   = rega_q;
            regb_d   = regb_q;
            rw_d     = 1'b0;
            rd_d     = 2'b00;
            mr_d     = 1'b0;
            mw_d     = 1'b0;
            ctrl_d   = '0;
            bubble_d = 1'b1;
        end else begin
            bubble_d = 1'b0;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            ir_q     <= 32'd0;
            pc_q     <= 32'd0;
            rega_q   <= 32'd0;
            regb_q   <= 32'd0;
            rw_q     <= 1'b0;
            rd_q     <= 2'b00;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            ctrl_q   <= '0;
            bubble_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            rega_q   <= rega_d;
            regb_q   <= regb_d;
            rw_q     <= rw_d;
            rd_q     <= rd_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            ctrl_q   <= ctrl_d;
            bubble_q <= bubble_d;
        end
    end

    assign IR_ID_EX_out       = ir_q;
    assign PC_ID_EX_out       = pc_q;
    assign RegA_ID_EX_out     = rega_q;
    assign RegB_ID_EX_out     = regb_q;
    assign RegWrite_ID_EX_out = rw_q;
    assign MemRead_ID_EX_out  = mr_q;
    assign MemWrite_ID_EX_out = mw_q;
    assign RegDst_ID_EX_out   = rd_q;
    assign Ctrl_ID_EX_out     = ctrl_q;
    assign Bubble_ID_EX       = bubble_q;
    assign Stall_IF_ID        = stall_s;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_s  ? stall_cnt_q + 32'd1 : stall_cnt_q;
            flush_cnt_q <= Flush_ID ? flush_cnt_q + 32'd1 : flush_cnt_q;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = 32'd0;
    assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: one instance with LU_STALL=1, one with LU_STALL=3.
module tb_id_ex_hazard_reg;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [31:0] LW8  = 32'h8D280000;
    localparam logic [31:0] LW0  = 32'h8D200000;
    localparam logic [31:0] ADD  = 32'h010B5020;
    localparam logic [31:0] ADD0 = 32'h00005020;
    localparam logic [31:0] IND  = 32'h012A5820;
    localparam logic [31:0] SW8  = 32'hAD280004;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] ir_id, pc_id, a_id, b_id;
    logic        rw_id, mr_id, mw_id, flush_id;
    logic [1:0]  rd_id;
    logic [7:0]  ctrl_id;

    logic [31:0] d1_ir, d1_pc, d1_a, d1_b, d1_scnt, d1_fcnt;
    logic        d1_rw, d1_mr, d1_mw, d1_stall, d1_bub;
    logic [1:0]  d1_rd;
    logic [7:0]  d1_ctrl;
    logic [31:0] d3_ir, d3_pc, d3_a, d3_b, d3_scnt, d3_fcnt;
    logic        d3_rw, d3_mr, d3_mw, d3_stall, d3_bub;
    logic [1:0]  d3_rd;
    logic [7:0]  d3_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_hazard_reg #(.LU_STALL(1), .CTRL_W(8)) dut1 (
        .clk(clk), .reset(reset), .IR_IF_ID_out(ir_id), .PC_IF_ID_out(pc_id),
        .RegA_ID(a_id), .RegB_ID(b_id), .RegWrite_ID(rw_id), .RegDst_ID(rd_id),
        .MemRead_ID(mr_id), .MemWrite_ID(mw_id), .Ctrl_ID(ctrl_id), .Flush_ID(flush_id),
        .IR_ID_EX_out(d1_ir), .PC_ID_EX_out(d1_pc), .RegA_ID_EX_out(d1_a), .RegB_ID_EX_out(d1_b),
        .RegWrite_ID_EX_out(d1_rw), .MemRead_ID_EX_out(d1_mr), .MemWrite_ID_EX_out(d1_mw),
        .RegDst_ID_EX_out(d1_rd), .Ctrl_ID_EX_out(d1_ctrl), .Stall_IF_ID(d1_stall),
        .Bubble_ID_EX(d1_bub), .StallCnt(d1_scnt), .FlushCnt(d1_fcnt)
    );

    id_ex_hazard_reg #(.LU_STALL(3), .CTRL_W(8)) dut3 (
        .clk(clk), .reset(reset), .IR_IF_ID_out(ir_id), .PC_IF_ID_out(pc_id),
        .RegA_ID(a_id), .RegB_ID(b_id), .RegWrite_ID(rw_id), .RegDst_ID(rd_id),
        .MemRead_ID(mr_id), .MemWrite_ID(mw_id), .Ctrl_ID(ctrl_id), .Flush_ID(flush_id),
        .IR_ID_EX_out(d3_ir), .PC_ID_EX_out(d3_pc), .RegA_ID_EX_out(d3_a), .RegB_ID_EX_out(d3_b),
        .RegWrite_ID_EX_out(d3_rw), .MemRead_ID_EX_out(d3_mr), .MemWrite_ID_EX_out(d3_mw),
        .RegDst_ID_EX_out(d3_rd), .Ctrl_ID_EX_out(d3_ctrl), .Stall_IF_ID(d3_stall),
        .Bubble_ID_EX(d3_bub), .StallCnt(d3_scnt), .FlushCnt(d3_fcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] ir, input logic [31:0] pc, input logic rw,
                          input logic mr, input logic mw, input logic [1:0] rd,
                          input logic [7:0] ctrl);
        ir_id = ir; pc_id = pc; rw_id = rw; mr_id = mr; mw_id = mw; rd_id = rd; ctrl_id = ctrl;
        a_id = ir ^ 32'hAAAAAAAA;
        b_id = pc + 32'd100;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        flush_id = 1'b0;
        set_id(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush_id = 1'b0;
        set_id(LW8, 32'h4, 1'b1, 1'b1, 1'b0, 2'b00, 8'hA5);
        #12;
        n_checks++; if ({d1_ir, d1_pc, d1_a, d1_b, d1_rw, d1_mr, d1_mw, d1_rd, d1_ctrl, d1_bub, d1_stall, d1_scnt, d1_fcnt} !== '0) begin n_fail++; $display("FAIL reset_d1: got ir=%h pc=%h bub=%b stall=%b want all 0", d1_ir, d1_pc, d1_bub, d1_stall); end
        n_checks++; if ({d3_ir, d3_pc, d3_a, d3_b, d3_rw, d3_mr, d3_mw, d3_rd, d3_ctrl, d3_bub, d3_stall, d3_scnt, d3_fcnt} !== '0) begin n_fail++; $display("FAIL reset_d3: got ir=%h pc=%h bub=%b stall=%b want all 0", d3_ir, d3_pc, d3_bub, d3_stall); end
        reset = 1'b1;
        tick();
        n_checks++; if (d1_ir !== LW8 || d1_mr !== 1'b1) begin n_fail++; $display("FAIL reset_release_capture: got ir=%h mr=%b want %h 1", d1_ir, d1_mr, LW8); end
    endtask

    task automatic test_load_use_lu1();
        do_reset();
        set_id(LW8, 32'h4, 1'b1, 1'b1, 1'b0, 2'b00, 8'hA5);
        #1;
        n_checks++; if (d1_stall !== 1'b0) begin n_fail++; $display("FAIL lu1_no_stall_empty_ex: got %b want 0", d1_stall); end
        tick();
        n_checks++; if (d1_ir !== LW8 || d1_mr !== 1'b1 || d1_bub !== 1'b0 || d1_ctrl !== 8'hA5) begin n_fail++; $display("FAIL lu1_lw_in_ex: got ir=%h mr=%b bub=%b ctrl=%h want %h 1 0 a5", d1_ir, d1_mr, d1_bub, d1_ctrl, LW8); end
        set_id(ADD, 32'h8, 1'b1, 1'b0, 1'b0, 2'b01, 8'h3C);
        #1;
        n_checks++; if (d1_stall !== 1'b1) begin n_fail++; $display("FAIL lu1_stall: got %b want 1", d1_stall); end
        tick();
        n_checks++; if (d1_ir !== 32'd0 || d1_bub !== 1'b1 || d1_rw !== 1'b0 || d1_mr !== 1'b0 || d1_ctrl !== 8'h00 || d1_rd !== 2'b00) begin n_fail++; $display("FAIL lu1_bubble: got ir=%h bub=%b rw=%b mr=%b ctrl=%h rd=%b want NOP bubble", d1_ir, d1_bub, d1_rw, d1_mr, d1_ctrl, d1_rd); end
        n_checks++; if (d1_pc !== 32'h4) begin n_fail++; $display("FAIL lu1_bubble_pc_hold: got %h want 4", d1_pc); end
        n_checks++; if (d1_stall !== 1'b0) begin n_fail++; $display("FAIL lu1_stall_released: got %b want 0", d1_stall); end
        tick();
        n_checks++; if (d1_ir !== ADD || d1_rd !== 2'b01 || d1_rw !== 1'b1 || d1_bub !== 1'b0 || d1_pc !== 32'h8 || d1_ctrl !== 8'h3C) begin n_fail++; $display("FAIL lu1_add_in_ex: got ir=%h rd=%b rw=%b bub=%b pc=%h want %h 01 1 0 8", d1_ir, d1_rd, d1_rw, d1_bub, d1_pc, ADD); end
        n_checks++; if (d1_a !== 32'hABA1FA8A || d1_b !== 32'd108) begin n_fail++; $display("FAIL lu1_operands: got a=%h b=%h want aba1fa8a 0000006c", d1_a, d1_b); end
        n_checks++; if (d1_scnt !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL lu1_stallcnt: got %0d want %0d", d1_scnt, PERF ? 1 : 0); end
    endtask

    task automatic test_rt_compare();
        do_reset();
        set_id(LW8, 32'h4, 1'b1, 1'b1, 1'b0, 2'b00, 8'h01);
        tick();
        set_id(IND, 32'h8, 1'b1, 1'b0, 1'b0, 2'b01, 8'h02);
        #1;
        n_checks++; if (d1_stall !== 1'b0) begin n_fail++; $display("FAIL rt_independent: got %b want 0", d1_stall); end
        set_id(SW8, 32'h8, 1'b0, 1'b0, 1'b1, 2'b00, 8'h03);
        #1;
        n_checks++; if (d1_stall !== 1'b1) begin n_fail++; $display("FAIL rt_match_stall: got %b want 1", d1_stall); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_id(LW0, 32'h4, 1'b1, 1'b1, 1'b0, 2'b00, 8'h10);
        tick();
        set_id(ADD0, 32'h8, 1'b1, 1'b0, 1'b0, 2'b01, 8'h20);
        #1;
        n_checks++; if (d3_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_r0_no_stall: got %b want 0", d3_stall); end
        tick();
        n_checks++; if (d3_ir !== ADD0 || d3_bub !== 1'b0 || d3_ctrl !== 8'h20) begin n_fail++; $display("FAIL b2b_add0: got ir=%h bub=%b want %h 0", d3_ir, d3_bub, ADD0); end
        set_id(IND, 32'h10, 1'b1, 1'b0, 1'b0, 2'b01, 8'h30);
        tick();
        n_checks++; if (d3_ir !== IND || d3_pc !== 32'h10 || d3_bub !== 1'b0) begin n_fail++; $display("FAIL b2b_ind: got ir=%h pc=%h bub=%b want %h 10 0", d3_ir, d3_pc, d3_bub, IND); end
    endtask

    task automatic test_lu3();
        do_reset();
        set_id(LW8, 32'h4, 1'b1, 1'b1, 1'b0, 2'b00, 8'hA5);
        tick();
        set_id(ADD, 32'h8, 1'b1, 1'b0, 1'b0, 2'b01, 8'h3C);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (d3_stall !== 1'b1) begin n_fail++; $display("FAIL lu3_stall_%0d: got %b want 1", i, d3_stall); end
            tick();
            n_checks++; if (d3_bub !== 1'b1 || d3_ir !== 32'd0) begin n_fail++; $display("FAIL lu3_bubble_%0d: got bub=%b ir=%h want 1 0", i, d3_bub, d3_ir); end
        end
        n_checks++; if (d3_stall !== 1'b0) begin n_fail++; $display("FAIL lu3_stall_end: got %b want 0", d3_stall); end
        tick();
        n_checks++; if (d3_ir !== ADD || d3_bub !== 1'b0) begin n_fail++; $display("FAIL lu3_add_4th_edge: got ir=%h bub=%b want %h 0", d3_ir, d3_bub, ADD); end
        n_checks++; if (d3_scnt !== (PERF ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL lu3_stallcnt: got %0d want %0d", d3_scnt, PERF ? 3 : 0); end
    endtask

    task automatic test_flush_abort();
        do_reset();
        set_id(LW8, 32'h4, 1'b1, 1'b1, 1'b0, 2'b00, 8'hA5);
        tick();
        set_id(ADD, 32'h8, 1'b1, 1'b0, 1'b0, 2'b01, 8'h3C);
        #1;
        n_checks++; if (d3_stall !== 1'b1) begin n_fail++; $display("FAIL abort_stall1: got %b want 1", d3_stall); end
        tick();
        flush_id = 1'b1;
        #1;
        n_checks++; if (d3_stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall_killed: got %b want 0", d3_stall); end
        tick();
        n_checks++; if (d3_bub !== 1'b1 || d3_ir !== 32'd0 || d3_rw !== 1'b0) begin n_fail++; $display("FAIL abort_bubble: got bub=%b ir=%h rw=%b want 1 0 0", d3_bub, d3_ir, d3_rw); end
        flush_id = 1'b0;
        set_id(IND, 32'h20, 1'b1, 1'b0, 1'b0, 2'b01, 8'h11);
        #1;
        n_checks++; if (d3_stall !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", d3_stall); end
        tick();
        n_checks++; if (d3_ir !== IND || d3_bub !== 1'b0) begin n_fail++; $display("FAIL abort_capture: got ir=%h bub=%b want %h 0", d3_ir, d3_bub, IND); end
        n_checks++; if (d3_fcnt !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL abort_flushcnt: got %0d want %0d", d3_fcnt, PERF ? 1 : 0); end
    endtask

    task automatic test_flush_plain();
        do_reset();
        set_id(ADD, 32'h30, 1'b1, 1'b0, 1'b0, 2'b01, 8'h7E);
        flush_id = 1'b1;
        #1;
        n_checks++; if (d1_stall !== 1'b0) begin n_fail++; $display("FAIL flush_no_stall: got %b want 0", d1_stall); end
        tick();
        n_checks++; if (d1_ir !== 32'd0 || d1_rw !== 1'b0 || d1_bub !== 1'b1 || d1_ctrl !== 8'h00) begin n_fail++; $display("FAIL flush_nop: got ir=%h rw=%b bub=%b ctrl=%h want 0 0 1 0", d1_ir, d1_rw, d1_bub, d1_ctrl); end
        n_checks++; if (d1_fcnt !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", d1_fcnt, PERF ? 1 : 0); end
        flush_id = 1'b0;
        tick();
        n_checks++; if (d1_ir !== ADD || d1_ctrl !== 8'h7E || d1_bub !== 1'b0) begin n_fail++; $display("FAIL flush_then_capture: got ir=%h ctrl=%h bub=%b want %h 7e 0", d1_ir, d1_ctrl, d1_bub, ADD); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(LW8, 32'h4, 1'b1, 1'b1, 1'b0, 2'b00, 8'hA5);
        tick();
        set_id(ADD, 32'h8, 1'b1, 1'b0, 1'b0, 2'b01, 8'h3C);
        tick();
        n_checks++; if (d3_stall !== 1'b1) begin n_fail++; $display("FAIL midrst_in_stall: got %b want 1", d3_stall); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if ({d3_ir, d3_pc, d3_a, d3_b, d3_rw, d3_mr, d3_mw, d3_rd, d3_ctrl, d3_bub, d3_scnt, d3_fcnt} !== '0) begin n_fail++; $display("FAIL midrst_outputs: got ir=%h pc=%h bub=%b want all 0", d3_ir, d3_pc, d3_bub); end
        n_checks++; if (d3_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b want 0", d3_stall); end
        #1;
        reset = 1'b1;
        tick();
        n_checks++; if (d3_ir !== ADD || d3_bub !== 1'b0) begin n_fail++; $display("FAIL midrst_capture: got ir=%h bub=%b want %h 0", d3_ir, d3_bub, ADD); end
    endtask

    initial begin
        test_reset();
        test_load_use_lu1();
        test_rt_compare();
        test_back_to_back();
        test_lu3();
        test_flush_abort();
        test_flush_plain();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
